// File: rtl/chiptest_seq_175.sv
// Clocked stimulus/check sequencer for a 74S175-style quad D flop; a run lasts (3+3*NVEC)*PHASE+1 cycles.
// Busy runs ignore start; results hold in DONE until the next accepted start or reset.
module chiptest_seq_175 #(
   parameter int         NVEC  = 16,
   parameter logic [3:0] PAT   = 4'hA,
   parameter int         PHASE = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [7:0] o_err_count,
   output logic [4:0] o_fail_step,
   output logic       o_dut_clr_n,
   output logic       o_dut_clk,
   output logic [3:0] o_dut_d,
   input  logic [3:0] i_dut_q,
   input  logic [3:0] i_dut_q_n
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR0, S_CHK0, S_SETUP, S_HIGH, S_LOW, S_CLRF, S_FIN, S_DONE
   } state_t;

   localparam logic [3:0] LP_PH_LAST  = 4'(PHASE - 1);
   localparam logic [3:0] LP_IDX_LAST = 4'(NVEC - 1);

   state_t     r_state;
   logic [3:0] r_phase;
   logic [3:0] r_idx;
   logic [3:0] r_shadow;
   logic [7:0] r_err;
   logic [4:0] r_fail;

   state_t     w_next;
   logic       w_accept;
   logic       w_last;
   logic       w_chk;
   logic       w_mismatch;
   logic [4:0] w_step;
   logic [3:0] w_vec;

   assign w_vec      = r_idx ^ PAT;
   assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
   assign w_last     = (r_phase == LP_PH_LAST);
   assign w_chk      = (r_state == S_CHK0) || (r_state == S_HIGH) || (r_state == S_CLRF);
   assign w_mismatch = (i_dut_q != r_shadow) || (i_dut_q_n != ~r_shadow);

   always_comb begin
      w_step = 5'd0;
      case (r_state)
         S_HIGH:  w_step = {1'b0, r_idx} + 5'd1;
         S_CLRF:  w_step = 5'd31;
         default: w_step = 5'd0;
      endcase
   end

   // State register plus the datapath registers that move with state transitions.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_phase  <= 4'd0;
         r_idx    <= 4'd0;
         r_shadow <= 4'd0;
         r_err    <= 8'd0;
         r_fail   <= 5'd0;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_DONE))
            r_phase <= 4'd0;
         else
            r_phase <= r_phase + 4'd1;

         if (w_accept) begin
            r_err    <= 8'd0;
            r_fail   <= 5'd0;
            r_shadow <= 4'd0;
            r_idx    <= 4'd0;
         end
         if ((r_state == S_SETUP) && w_last)
            r_shadow <= w_vec;
         if ((r_state == S_LOW) && w_last) begin
            if (r_idx == LP_IDX_LAST)
               r_shadow <= 4'd0;
            else
               r_idx <= r_idx + 4'd1;
         end
         // A zero count marks the first failure of the run.
         if (w_chk && w_last && w_mismatch) begin
            if (r_err != 8'hFF)
               r_err <= r_err + 8'd1;
            if (r_err == 8'd0)
               r_fail <= w_step;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_CLR0;
         S_CLR0:  if (w_last) w_next = S_CHK0;
         S_CHK0:  if (w_last) w_next = S_SETUP;
         S_SETUP: if (w_last) w_next = S_HIGH;
         S_HIGH:  if (w_last) w_next = S_LOW;
         S_LOW:   if (w_last) w_next = (r_idx == LP_IDX_LAST) ? S_CLRF : S_SETUP;
         S_CLRF:  if (w_last) w_next = S_FIN;
         S_FIN:   w_next = S_DONE;
         S_DONE:  if (i_start) w_next = S_CLR0;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
      o_done      = (r_state == S_DONE);
      o_pass      = (r_state == S_DONE) && (r_err == 8'd0);
      o_err_count = r_err;
      o_fail_step = r_fail;
      o_dut_clr_n = 1'b1;
      o_dut_clk   = 1'b0;
      o_dut_d     = 4'd0;
      case (r_state)
         S_CLR0, S_CHK0: o_dut_clr_n = 1'b0;
         S_SETUP, S_LOW, S_FIN: o_dut_d = w_vec;
         S_HIGH: begin
            o_dut_clk = 1'b1;
            o_dut_d   = w_vec;
         end
         S_CLRF: begin
            o_dut_clr_n = 1'b0;
            o_dut_d     = w_vec;
         end
         default: ;
      endcase
   end

endmodule
